// File: rtl/tx_fifo_wr_arb_if.sv
// Handshake and FIFO write-port bundle for tx_fifo_wr_arb.
// slave = arbiter side, master = requester/FIFO side.
interface tx_fifo_wr_arb_if #(
    parameter int DATA_WIDTH = 8
);
    logic                      RF_RD_VLD;
    logic [DATA_WIDTH-1:0]     RF_RD_DATA;
    logic                      RF_RDY;
    logic                      ALU_OUT_VLD;
    logic [2*DATA_WIDTH-1:0]   ALU_OUT;
    logic                      ALU_RDY;
    logic                      FIFO_FULL;
    logic                      WR_INC;
    logic [DATA_WIDTH-1:0]     WR_DATA;
    logic                      BUSY;

    modport slave (
        input  RF_RD_VLD, RF_RD_DATA, ALU_OUT_VLD, ALU_OUT, FIFO_FULL,
        output RF_RDY, ALU_RDY, WR_INC, WR_DATA, BUSY
    );

    modport master (
        output RF_RD_VLD, RF_RD_DATA, ALU_OUT_VLD, ALU_OUT, FIFO_FULL,
        input  RF_RDY, ALU_RDY, WR_INC, WR_DATA, BUSY
    );
endinterface

// File: rtl/tx_fifo_wr_arb.sv
// Write-port arbiter/sequencer for the TX async FIFO: grants RF (1 byte) or ALU (2 bytes, low first).
// Define TX_ARB_RR_EN for round-robin tie-breaking; default is fixed priority with RF first.
module tx_fifo_wr_arb #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                 REF_CLK,
    input  logic                 RST,
    tx_fifo_wr_arb_if.slave      bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WR_RF = 2'd1,
        S_WR_LO = 2'd2,
        S_WR_HI = 2'd3
    } state_t;

    state_t                    r_state;
    logic                      r_last_gnt_alu;
    logic [2*DATA_WIDTH-1:0]   r_cap;

    logic                      w_tie_rf;
    logic                      w_gnt_rf;
    logic                      w_gnt_alu;
    logic                      w_rf_rdy;
    logic                      w_alu_rdy;
    logic                      w_wr_inc;
    logic [DATA_WIDTH-1:0]     w_wr_data;

    // Tie-break selection between the two requesters.
`ifdef TX_ARB_RR_EN
    assign w_tie_rf = r_last_gnt_alu;
`else
    // Fixed priority: RF wins every tie whatever last_gnt holds.
    assign w_tie_rf = r_last_gnt_alu | ~r_last_gnt_alu;
`endif

    // Grant decode and ready generation; readies only in IDLE and never during reset.
    always_comb begin
        w_gnt_rf  = 1'b0;
        w_gnt_alu = 1'b0;
        if (bus.RF_RD_VLD && bus.ALU_OUT_VLD) begin
            w_gnt_rf  = w_tie_rf;
            w_gnt_alu = ~w_tie_rf;
        end else begin
            w_gnt_rf  = bus.RF_RD_VLD;
            w_gnt_alu = bus.ALU_OUT_VLD;
        end
        if (!RST && (r_state == S_IDLE)) begin
            w_rf_rdy  = w_gnt_rf;
            w_alu_rdy = w_gnt_alu;
        end else begin
            w_rf_rdy  = 1'b0;
            w_alu_rdy = 1'b0;
        end
    end

    // FIFO write strobe and byte select follow the state directly so the FIFO samples them next edge.
    always_comb begin
        w_wr_inc  = 1'b0;
        w_wr_data = r_cap[DATA_WIDTH-1:0];
        case (r_state)
            S_WR_RF, S_WR_LO: begin
                w_wr_data = r_cap[DATA_WIDTH-1:0];
                w_wr_inc  = ~bus.FIFO_FULL;
            end
            S_WR_HI: begin
                w_wr_data = r_cap[2*DATA_WIDTH-1:DATA_WIDTH];
                w_wr_inc  = ~bus.FIFO_FULL;
            end
            default: begin
                w_wr_data = r_cap[DATA_WIDTH-1:0];
                w_wr_inc  = 1'b0;
            end
        endcase
    end

    // Sequencer: capture on accept, then step through the byte writes as FIFO space allows.
    always_ff @(posedge REF_CLK or posedge RST) begin
        if (RST) begin
            r_state        <= S_IDLE;
            r_last_gnt_alu <= 1'b1;
            r_cap          <= {(2*DATA_WIDTH){1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.RF_RD_VLD && w_rf_rdy) begin
                        r_cap          <= {{DATA_WIDTH{1'b0}}, bus.RF_RD_DATA};
                        r_state        <= S_WR_RF;
                        r_last_gnt_alu <= 1'b0;
                    end else if (bus.ALU_OUT_VLD && w_alu_rdy) begin
                        r_cap          <= bus.ALU_OUT;
                        r_state        <= S_WR_LO;
                        r_last_gnt_alu <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WR_RF: begin
                    if (!bus.FIFO_FULL) r_state <= S_IDLE;
                    else                r_state <= S_WR_RF;
                end
                S_WR_LO: begin
                    if (!bus.FIFO_FULL) r_state <= S_WR_HI;
                    else                r_state <= S_WR_LO;
                end
                S_WR_HI: begin
                    if (!bus.FIFO_FULL) r_state <= S_IDLE;
                    else                r_state <= S_WR_HI;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.RF_RDY  = w_rf_rdy;
    assign bus.ALU_RDY = w_alu_rdy;
    assign bus.WR_INC  = w_wr_inc;
    assign bus.WR_DATA = w_wr_data;
    assign bus.BUSY    = (r_state != S_IDLE);
endmodule

// File: tb/tb_tx_fifo_wr_arb.sv
// Self-checking bench for tx_fifo_wr_arb: directed scenarios plus a randomized run
// checked against a byte-queue reference model of the FIFO write stream.
`timescale 1ns/1ps
module tb_tx_fifo_wr_arb;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    tx_fifo_wr_arb_if #(.DATA_WIDTH(8)) bus ();

    tx_fifo_wr_arb #(.DATA_WIDTH(8)) dut (
        .REF_CLK (clk),
        .RST     (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs;
        bus.RF_RD_VLD   = 1'b0;
        bus.RF_RD_DATA  = 8'h00;
        bus.ALU_OUT_VLD = 1'b0;
        bus.ALU_OUT     = 16'h0000;
        bus.FIFO_FULL   = 1'b0;
    endtask

    task automatic apply_reset;
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.RF_RD_VLD   = 1'b1;
        bus.RF_RD_DATA  = 8'h5A;
        bus.ALU_OUT_VLD = 1'b1;
        bus.ALU_OUT     = 16'h1357;
        bus.FIFO_FULL   = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.RF_RDY !== 1'b0) begin errors++; $display("FAIL reset_rf_rdy got=%b exp=0", bus.RF_RDY); end
        checks++; if (bus.ALU_RDY !== 1'b0) begin errors++; $display("FAIL reset_alu_rdy got=%b exp=0", bus.ALU_RDY); end
        checks++; if (bus.WR_INC !== 1'b0) begin errors++; $display("FAIL reset_wr_inc got=%b exp=0", bus.WR_INC); end
        checks++; if (bus.WR_DATA !== 8'h00) begin errors++; $display("FAIL reset_wr_data got=%h exp=00", bus.WR_DATA); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.BUSY); end
        idle_inputs();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_rf_single;
        apply_reset();
        @(posedge clk); #1;
        bus.RF_RD_VLD  = 1'b1;
        bus.RF_RD_DATA = 8'hA5;
        @(negedge clk);
        checks++; if (bus.RF_RDY !== 1'b1) begin errors++; $display("FAIL rf_rdy_c0 got=%b exp=1", bus.RF_RDY); end
        checks++; if (bus.ALU_RDY !== 1'b0) begin errors++; $display("FAIL rf_alu_rdy_c0 got=%b exp=0", bus.ALU_RDY); end
        @(posedge clk); #1;
        bus.RF_RD_VLD = 1'b0;
        @(negedge clk);
        checks++; if (bus.WR_INC !== 1'b1) begin errors++; $display("FAIL rf_wr_inc_c1 got=%b exp=1", bus.WR_INC); end
        checks++; if (bus.WR_DATA !== 8'hA5) begin errors++; $display("FAIL rf_wr_data_c1 got=%h exp=a5", bus.WR_DATA); end
        checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL rf_busy_c1 got=%b exp=1", bus.BUSY); end
        @(negedge clk);
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL rf_busy_c2 got=%b exp=0", bus.BUSY); end
        checks++; if (bus.WR_INC !== 1'b0) begin errors++; $display("FAIL rf_wr_inc_c2 got=%b exp=0", bus.WR_INC); end
    endtask

    task automatic test_alu;
        apply_reset();
        @(posedge clk); #1;
        bus.ALU_OUT_VLD = 1'b1;
        bus.ALU_OUT     = 16'h1234;
        @(negedge clk);
        checks++; if (bus.ALU_RDY !== 1'b1) begin errors++; $display("FAIL alu_rdy_c0 got=%b exp=1", bus.ALU_RDY); end
        @(posedge clk); #1;
        bus.ALU_OUT_VLD = 1'b0;
        @(negedge clk);
        checks++; if (bus.WR_INC !== 1'b1 || bus.WR_DATA !== 8'h34) begin errors++; $display("FAIL alu_lo_c1 got=%b/%h exp=1/34", bus.WR_INC, bus.WR_DATA); end
        @(negedge clk);
        checks++; if (bus.WR_INC !== 1'b1 || bus.WR_DATA !== 8'h12) begin errors++; $display("FAIL alu_hi_c2 got=%b/%h exp=1/12", bus.WR_INC, bus.WR_DATA); end
        @(negedge clk);
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL alu_busy_c3 got=%b exp=0", bus.BUSY); end
    endtask

    task automatic test_backpressure;
        apply_reset();
        @(posedge clk); #1;
        bus.ALU_OUT_VLD = 1'b1;
        bus.ALU_OUT     = 16'hBEEF;
        @(negedge clk);
        checks++; if (bus.ALU_RDY !== 1'b1) begin errors++; $display("FAIL bp_alu_rdy got=%b exp=1", bus.ALU_RDY); end
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            bus.ALU_OUT_VLD = 1'b0;
            bus.FIFO_FULL   = 1'b1;
            @(negedge clk);
            checks++; if (bus.WR_INC !== 1'b0 || bus.WR_DATA !== 8'hEF) begin errors++; $display("FAIL bp_hold_c%0d got=%b/%h exp=0/ef", i, bus.WR_INC, bus.WR_DATA); end
        end
        @(posedge clk); #1;
        bus.FIFO_FULL = 1'b0;
        @(negedge clk);
        checks++; if (bus.WR_INC !== 1'b1 || bus.WR_DATA !== 8'hEF) begin errors++; $display("FAIL bp_lo_c4 got=%b/%h exp=1/ef", bus.WR_INC, bus.WR_DATA); end
        @(negedge clk);
        checks++; if (bus.WR_INC !== 1'b1 || bus.WR_DATA !== 8'hBE) begin errors++; $display("FAIL bp_hi_c5 got=%b/%h exp=1/be", bus.WR_INC, bus.WR_DATA); end
        @(negedge clk);
        checks++; if (bus.BUSY !== 1'b0 || bus.WR_INC !== 1'b0) begin errors++; $display("FAIL bp_done_c6 got=%b/%b exp=0/0", bus.BUSY, bus.WR_INC); end
    endtask

    task automatic test_tie;
        logic [7:0] got[$];
        logic [7:0] exp[$];
        bit         alu_seen;
        bit         both_seen;
        apply_reset();
        alu_seen  = 1'b0;
        both_seen = 1'b0;
`ifdef TX_ARB_RR_EN
        exp = '{8'h11, 8'h33, 8'h22, 8'h11, 8'h11};
`else
        exp = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11};
`endif
        bus.RF_RD_VLD   = 1'b1;
        bus.RF_RD_DATA  = 8'h11;
        bus.ALU_OUT_VLD = 1'b1;
        bus.ALU_OUT     = 16'h2233;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.WR_INC === 1'b1) got.push_back(bus.WR_DATA);
            if (bus.ALU_RDY === 1'b1) alu_seen = 1'b1;
            if (bus.RF_RDY === 1'b1 && bus.ALU_RDY === 1'b1) both_seen = 1'b1;
            @(posedge clk); #1;
            if (alu_seen) bus.ALU_OUT_VLD = 1'b0;
        end
        idle_inputs();
        checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL tie_count got=%0d exp=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL tie_byte%0d got=%h exp=%h", i, got[i], exp[i]); end
        end
`ifdef TX_ARB_RR_EN
        checks++; if (alu_seen !== 1'b1) begin errors++; $display("FAIL tie_alu_served got=%b exp=1", alu_seen); end
`else
        checks++; if (alu_seen !== 1'b0) begin errors++; $display("FAIL tie_alu_starved got=%b exp=0", alu_seen); end
`endif
        checks++; if (both_seen !== 1'b0) begin errors++; $display("FAIL tie_rdy_excl got=%b exp=0", both_seen); end
    endtask

    task automatic test_reset_mid;
        apply_reset();
        @(posedge clk); #1;
        bus.ALU_OUT_VLD = 1'b1;
        bus.ALU_OUT     = 16'hCAFE;
        @(posedge clk); #1;
        bus.ALU_OUT_VLD = 1'b0;
        @(negedge clk);
        checks++; if (bus.WR_INC !== 1'b1 || bus.WR_DATA !== 8'hFE) begin errors++; $display("FAIL rm_lo got=%b/%h exp=1/fe", bus.WR_INC, bus.WR_DATA); end
        @(posedge clk); #1;
        checks++; if (bus.WR_INC !== 1'b1 || bus.WR_DATA !== 8'hCA) begin errors++; $display("FAIL rm_hi_pre got=%b/%h exp=1/ca", bus.WR_INC, bus.WR_DATA); end
        rst = 1'b1;
        #1;
        checks++; if (bus.WR_INC !== 1'b0) begin errors++; $display("FAIL rm_wr_inc_async got=%b exp=0", bus.WR_INC); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL rm_busy_async got=%b exp=0", bus.BUSY); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.WR_INC !== 1'b0 || bus.BUSY !== 1'b0 || bus.WR_DATA !== 8'h00) begin errors++; $display("FAIL rm_after%0d got=%b/%b/%h exp=0/0/00", i, bus.WR_INC, bus.BUSY, bus.WR_DATA); end
        end
    endtask

    task automatic test_handshake;
        apply_reset();
        @(posedge clk); #1;
        bus.ALU_OUT_VLD = 1'b1;
        bus.ALU_OUT     = 16'h5678;
        @(negedge clk);
        checks++; if (bus.ALU_RDY !== 1'b1) begin errors++; $display("FAIL hs_alu_rdy got=%b exp=1", bus.ALU_RDY); end
        for (int i = 1; i <= 2; i++) begin
            @(posedge clk); #1;
            bus.ALU_OUT_VLD = 1'b0;
            bus.RF_RD_VLD   = 1'b1;
            bus.RF_RD_DATA  = 8'h9C;
            @(negedge clk);
            checks++; if (bus.RF_RDY !== 1'b0 || bus.ALU_RDY !== 1'b0) begin errors++; $display("FAIL hs_busy_rdy_c%0d got=%b/%b exp=0/0", i, bus.RF_RDY, bus.ALU_RDY); end
        end
        @(negedge clk);
        checks++; if (bus.RF_RDY !== 1'b1) begin errors++; $display("FAIL hs_rf_rdy_idle got=%b exp=1", bus.RF_RDY); end
        @(posedge clk); #1;
        bus.RF_RD_VLD = 1'b0;
        @(negedge clk);
        checks++; if (bus.WR_INC !== 1'b1 || bus.WR_DATA !== 8'h9C) begin errors++; $display("FAIL hs_rf_write got=%b/%h exp=1/9c", bus.WR_INC, bus.WR_DATA); end
    endtask

    // Reference: a queue of bytes still owed to the FIFO; the arbiter is idle exactly when it is empty.
    task automatic test_random;
        logic [7:0] q[$];
        bit         last_was_alu;
        bit         exp_rf;
        bit         exp_alu;
        bit         exp_wr;
        bit         rf_acc;
        bit         alu_acc;
        apply_reset();
        last_was_alu = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (!bus.RF_RD_VLD && $urandom_range(0, 1) == 1) begin
                bus.RF_RD_VLD  = 1'b1;
                bus.RF_RD_DATA = 8'($urandom);
            end
            if (!bus.ALU_OUT_VLD && $urandom_range(0, 1) == 1) begin
                bus.ALU_OUT_VLD = 1'b1;
                bus.ALU_OUT     = 16'($urandom);
            end
            bus.FIFO_FULL = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            exp_rf  = 1'b0;
            exp_alu = 1'b0;
            if (q.size() == 0) begin
                if (bus.RF_RD_VLD && bus.ALU_OUT_VLD) begin
`ifdef TX_ARB_RR_EN
                    exp_rf = last_was_alu;
`else
                    exp_rf = 1'b1;
`endif
                    exp_alu = !exp_rf;
                end else begin
                    exp_rf  = bus.RF_RD_VLD;
                    exp_alu = bus.ALU_OUT_VLD;
                end
            end
            exp_wr = (q.size() != 0) && !bus.FIFO_FULL;
            checks++; if (bus.RF_RDY !== exp_rf) begin errors++; $display("FAIL rnd_rf_rdy cyc=%0d got=%b exp=%b", c, bus.RF_RDY, exp_rf); end
            checks++; if (bus.ALU_RDY !== exp_alu) begin errors++; $display("FAIL rnd_alu_rdy cyc=%0d got=%b exp=%b", c, bus.ALU_RDY, exp_alu); end
            checks++; if (bus.BUSY !== (q.size() != 0)) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", c, bus.BUSY, q.size() != 0); end
            checks++; if (bus.WR_INC !== exp_wr) begin errors++; $display("FAIL rnd_wr_inc cyc=%0d got=%b exp=%b", c, bus.WR_INC, exp_wr); end
            if (q.size() != 0) begin
                checks++; if (bus.WR_DATA !== q[0]) begin errors++; $display("FAIL rnd_wr_data cyc=%0d got=%h exp=%h", c, bus.WR_DATA, q[0]); end
            end
            if (exp_wr) void'(q.pop_front());
            if (exp_rf) begin
                q.push_back(bus.RF_RD_DATA);
                last_was_alu = 1'b0;
            end
            if (exp_alu) begin
                q.push_back(bus.ALU_OUT[7:0]);
                q.push_back(bus.ALU_OUT[15:8]);
                last_was_alu = 1'b1;
            end
            rf_acc  = bus.RF_RDY;
            alu_acc = bus.ALU_RDY;
            @(posedge clk); #1;
            if (rf_acc)  bus.RF_RD_VLD   = 1'b0;
            if (alu_acc) bus.ALU_OUT_VLD = 1'b0;
        end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_rf_single();
        test_alu();
        test_backpressure();
        test_tie();
        test_reset_mid();
        test_handshake();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tx_fifo_wr_arb.md
# tx_fifo_wr_arb

Arbiter and sequencer for the shared write port of the REF_CLK-side TX async FIFO. Two requesters feed it: register-file read responses (one byte) and ALU results (16 bits, sent as two bytes). The block grants one requester at a time and captures its data. It then writes the bytes into the FIFO in order, honouring FIFO_FULL backpressure. It sits between the system controller datapath and the async FIFO that feeds the UART transmitter.

## Interface
Parameters:
- DATA_WIDTH, 8: FIFO word width; the ALU result is 2*DATA_WIDTH.

Ports (clock: one; reset: asynchronous, active-high):
- REF_CLK  in  1  sole clock.
- RST  in  1  asynchronous, active-high reset.
- RF_RD_VLD  in  1  register-file read data valid.
- RF_RD_DATA  in  DATA_WIDTH  register-file read data.
- RF_RDY  out  1  register-file requester accepted this cycle.
- ALU_OUT_VLD  in  1  ALU result valid.
- ALU_OUT  in  2*DATA_WIDTH  ALU result.
- ALU_RDY  out  1  ALU requester accepted this cycle.
- FIFO_FULL  in  1  FIFO write-side full flag, already synchronised to REF_CLK.
- WR_INC  out  1  FIFO write strobe; one word is written per cycle it is high.
- WR_DATA  out  DATA_WIDTH  FIFO write data.
- BUSY  out  1  a transaction is captured and not yet fully written.

## Operation
- FSM states: IDLE, WR_RF, WR_LO, WR_HI. Reset state is IDLE.
- IDLE behaviour:
  - Grant is combinational from the VLD inputs and last_gnt.
  - Only one VLD high: that requester is granted.
  - Both VLD high: arbitrated per Configuration.
  - The granted requester's RDY goes high in the same cycle. RDY may depend on VLD.
  - RF_RDY and ALU_RDY are never high together, and both are 0 outside IDLE.
- Accept = VLD && RDY.
  - On an RF accept: cap_reg[7:0] <= RF_RD_DATA, state <= WR_RF, last_gnt <= RF.
  - On an ALU accept: cap_reg <= ALU_OUT, state <= WR_LO, last_gnt <= ALU.
- WR_RF: WR_DATA = cap_reg[7:0]. When !FIFO_FULL, WR_INC=1 and the next state is IDLE.
- WR_LO: WR_DATA = cap_reg[7:0]. When !FIFO_FULL, WR_INC=1 and the next state is WR_HI.
- WR_HI: WR_DATA = cap_reg[15:8]. When !FIFO_FULL, WR_INC=1 and the next state is IDLE.
- FIFO_FULL high in any write state: WR_INC=0, the state holds and WR_DATA is held stable. There is no timeout.
- Byte order for ALU results is always low byte first. No byte is ever dropped or duplicated.
- Requester inputs are ignored outside IDLE. Requesters must hold VLD and data until their RDY is seen.
- BUSY = (state != IDLE).

## Timing
- Reset values: state=IDLE, last_gnt=ALU (so RF wins the first tie), cap_reg=0, WR_INC=0, WR_DATA=0, BUSY=0. RF_RDY and ALU_RDY are forced 0 while RST is high.
- Latency:
  - Accept in cycle N; first WR_INC in cycle N+1 if FIFO_FULL is low.
  - An RF transaction occupies 2 cycles minimum.
  - An ALU transaction occupies 3 cycles minimum.
- One IDLE cycle always separates transactions (the accept cycle), so peak throughput is 1 byte per 2 cycles for RF traffic.
- WR_INC and WR_DATA are combinational from the state, cap_reg and FIFO_FULL. The FIFO samples them on the next REF_CLK edge.
- FIFO_FULL rising in the same cycle as a write state: the write is suppressed that cycle and retried.
- RST asserted mid-transaction: the captured data is discarded, and WR_INC drops immediately (asynchronously) to 0.

## Configuration
- TX_ARB_RR_EN defined: round-robin arbitration. On a tie, the requester not equal to last_gnt wins.
- TX_ARB_RR_EN undefined: fixed priority, RF always beats ALU on a tie. last_gnt is still maintained but unused.

## Test plan
- Single RF read: RF_RD_VLD=1, RF_RD_DATA=8'hA5, FIFO_FULL=0 -> RF_RDY=1 in cycle 0; WR_INC=1 with WR_DATA=8'hA5 in cycle 1; BUSY=0 in cycle 2.
- ALU result: ALU_OUT=16'h1234 -> WR_INC writes 8'h34 in cycle 1, then 8'h12 in cycle 2.
- Backpressure:
  - Stimulus: ALU_OUT=16'hBEEF, with FIFO_FULL=1 for cycles 1-3.
  - Response: no WR_INC during cycles 1-3 and WR_DATA held at 8'hEF.
  - Response: 8'hEF is written in cycle 4 and 8'hBE in cycle 5.
- Simultaneous requests: RF 8'h11 and ALU 16'h2233 both valid from reset.
  - With TX_ARB_RR_EN: FIFO order is 11, 33, 22; a second tie is granted to RF again only after ALU has been served.
  - Without TX_ARB_RR_EN: RF always wins while RF_RD_VLD stays high.
- Reset mid-op: RST asserted in WR_HI -> WR_INC=0 immediately, and after release state=IDLE and BUSY=0, with no high byte written.
- Handshake integrity: RF_RD_VLD is held during an ALU transaction -> RF_RDY=0 until IDLE, and RF_RDY and ALU_RDY are never both 1 (assertion).
